// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multi-cycle integer multiply/divide unit with HI/LO registers.
//            Executes MULTU/MULT/DIVU/DIV over WIDTH iteration cycles using an
//            unsigned shift-add / restoring-subtract datapath on operand
//            magnitudes; the sign is applied when the result is written.
//            Also provides MTHI/MTLO write paths.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            start, op              - launch request and operation select
//                                     (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//            operandA, operandB     - rs / rt operands
//            writeHi, writeLo,
//            writeData              - MTHI / MTLO write path
//            busy, done, divByZero  - status
//            hi, lo                 - HI / LO result registers
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_count;
    // Multiply: {partial product upper, multiplier being shifted out}
    // Divide  : {partial remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic                 r_is_div;
    logic                 r_neg_q;    // negate product / quotient
    logic                 r_neg_r;    // negate remainder (dividend sign)
    logic                 r_b_zero;

    // Operand magnitudes at accept time
    logic                 w_sign_a, w_sign_b;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;

    assign w_sign_a = op[0] & operandA[WIDTH-1];
    assign w_sign_b = op[0] & operandB[WIDTH-1];
    assign w_abs_a  = w_sign_a ? (~operandA + 1'b1) : operandA;
    assign w_abs_b  = w_sign_b ? (~operandB + 1'b1) : operandB;

    // One shift-add multiply step
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring-divide step; a zero divisor always "subtracts", which
    // leaves the dividend magnitude in the remainder half after WIDTH steps.
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_next  = w_div_ge
                       ? {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1}
                       : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   w_acc_next;
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // Sign fix-up of the final iteration's result
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot, w_rem;
    logic [WIDTH-1:0]     w_res_hi, w_res_lo;

    assign w_prod = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quot = r_b_zero ? {WIDTH{1'b1}}
                  : (r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1)
                             : w_acc_next[WIDTH-1:0]);
    assign w_rem  = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                            : w_acc_next[2*WIDTH-1:WIDTH];

    assign w_res_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous MTHI/MTLO
                        r_state   <= S_RUN;
                        busy      <= 1'b1;
                        divByZero <= 1'b0;
                        r_count   <= '0;
                        r_is_div  <= op[1];
                        r_neg_q   <= w_sign_a ^ w_sign_b;
                        r_neg_r   <= w_sign_a;
                        r_b_zero  <= (operandB == '0);
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                        r_opb     <= op[1] ? w_abs_b : w_abs_a;
                    end else begin
                        if (writeHi) hi <= writeData;
                        if (writeLo) lo <= writeData;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last_iter) begin
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        hi        <= w_res_hi;
                        lo        <= w_res_lo;
                        divByZero <= r_is_div & r_b_zero;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the MIPS-style datapath. It sits directly downstream of the register file and consumes readData1 (rs) and readData2 (rt) as operands. It executes MULT, MULTU, DIV and DIVU over 32 iteration cycles and holds the 64-bit result in the HI/LO registers. It also provides MTHI/MTLO write paths and feeds HI/LO back to the write-back mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch the operation selected by op; sampled only when busy=0
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
operandA  input  32  rs value (multiplicand / dividend), from readData1
operandB  input  32  rt value (multiplier / divisor), from readData2
writeHi  input  1  MTHI: load writeData into hi
writeLo  input  1  MTLO: load writeData into lo
writeData  input  32  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo hold a new result
divByZero  output  1  set with done when a DIV/DIVU had operandB=0; cleared at next accepted start
hi  output  32  HI register (product upper / remainder)
lo  output  32  LO register (product lower / quotient)

Behaviour:
- Reset (synchronous, active-high, takes priority over everything else): state=IDLE; busy=0; done=0; divByZero=0; hi=0; lo=0. Reset asserted mid-operation aborts the operation and produces no done.
- States: IDLE, RUN. IDLE->RUN on start. RUN->IDLE after 32 iterations. There is no separate done state.
- Accept: start=1 with busy=0 at edge N. The unit latches op, operandA and operandB at that edge. Operand changes after edge N have no effect.
- Timing: busy=1 from edge N through edge N+32, i.e. for 32 cycles. At edge N+32, hi/lo are updated, busy drops to 0 and done rises to 1. done returns to 0 at edge N+33 unless a new result completes.
- start while busy=1 is ignored. It is not queued.
- start in the cycle where done=1 is accepted, because busy=0 then.
- Signed ops: the unit works on absolute values, using an unsigned 32-bit shift-add or restoring-subtract datapath. The sign is fixed when the result is written.
  - MULT: the 64-bit product is negated if the operand signs differ.
  - DIV: the quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- Result placement: MULT/MULTU puts product[63:32] in hi and product[31:0] in lo. DIV/DIVU puts the remainder in hi and the quotient in lo.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0. No flag is raised.
- Divide by zero: the operation still takes 32 cycles. Result is hi=dividend (as presented), lo=0xFFFFFFFF, and divByZero=1 together with done. divByZero holds until the next accepted start or reset.
- MTHI/MTLO: when busy=0 and start=0, writeHi/writeLo load writeData into hi/lo at the edge. Both may be asserted in the same cycle.
- MTHI/MTLO conflicts: writeHi/writeLo are ignored while busy=1. They are also ignored in a cycle where start is accepted, since start has priority.
- hi/lo are stable, holding their old values, throughout RUN. They change only at the completion edge, on MTHI/MTLO, or on reset.

Test Plan:
- MULTU 6 x 7: start for 1 cycle -> busy high for exactly 32 cycles, then done pulse for 1 cycle with hi=0x00000000, lo=0x0000002A.
- MULT 0xFFFFFFFD x 5, then MULTU 0xFFFFFFFF x 0xFFFFFFFF started in the done cycle -> first result hi=0xFFFFFFFF, lo=0xFFFFFFF1; second result hi=0xFFFFFFFE, lo=0x00000001 after 32 more cycles.
- DIV 0xFFFFFFF9 / 2, then DIV 0x80000000 / 0xFFFFFFFF -> first result lo=0xFFFFFFFD, hi=0xFFFFFFFF; second result lo=0x80000000, hi=0x00000000, with divByZero=0 for both.
- DIVU 100 / 0 -> done with divByZero=1, hi=0x00000064, lo=0xFFFFFFFF. A following MULTU 1 x 1 start clears divByZero.
- Start MULTU 3 x 3, pulse start with DIVU 9 / 3 at cycle 5 and writeHi=1 with writeData=0x1234 at cycle 6, then assert reset at cycle 10 -> the second start and the MTHI are ignored; after reset, busy=0, done never pulses, hi=lo=0.
- With the unit idle, writeHi=1, writeLo=1, writeData=0xDEADBEEF -> hi=lo=0xDEADBEEF on the next edge. done stays 0.
